// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses framed packets from uart_rx and writes the payload into program RAM.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_prog_loader #(
    parameter int unsigned          ADDR_W      = 16,
    parameter logic [7:0]           SYNC_BYTE   = 8'hA5,
    parameter int unsigned          TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(20'hFFFFF),
    parameter int unsigned          REBOOT_CYC  = 80
) (
    input  logic              clk_ram,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_strobe,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              write_en,
    output logic              ask_for_ram,
    output logic              end_of_data,
    output logic              load_ok,
    output logic              load_err
);

    localparam int unsigned RB_W = (REBOOT_CYC > 2) ? $clog2(REBOOT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_REBOOT
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CHK;
`else
    localparam state_t S_AFTER = S_REBOOT;
`endif

    state_t                 state, state_nxt;
    logic [7:0]             addr_h, len_h;
    logic [ADDR_W-1:0]      ptr;
    logic [15:0]            rem;
    logic [TIMEOUT_W-1:0]   tmo;
    logic [RB_W-1:0]        rb_cnt;
    logic                   active, expired;
    logic                   wr_c, ok_c, err_c;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]             chk;
`endif

    assign active  = (state inside {S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK});
    // A strobe in the expiry cycle takes priority over the abort.
    assign expired = active && !rx_data_strobe && (tmo == '0);

    always_ff @(posedge clk_ram) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rx_data_strobe && rx_data == SYNC_BYTE) state_nxt = S_ADDR_H;
            S_ADDR_H: if (rx_data_strobe) state_nxt = S_ADDR_L;
            S_ADDR_L: if (rx_data_strobe) state_nxt = S_LEN_H;
            S_LEN_H:  if (rx_data_strobe) state_nxt = S_LEN_L;
            S_LEN_L:  if (rx_data_strobe)
                          state_nxt = ({len_h, rx_data} == 16'd0) ? S_AFTER : S_DATA;
            S_DATA:   if (rx_data_strobe && rem == 16'd1) state_nxt = S_AFTER;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:    if (rx_data_strobe) state_nxt = (rx_data == chk) ? S_REBOOT : S_IDLE;
`endif
            S_REBOOT: if (rb_cnt == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (expired) state_nxt = S_IDLE;
    end

    // Event pulses, derived from the transition about to happen.
    always_comb begin
        wr_c  = 1'b0;
        ok_c  = 1'b0;
        err_c = 1'b0;
        wr_c  = (state == S_DATA) && rx_data_strobe;
        ok_c  = (state != S_REBOOT) && (state_nxt == S_REBOOT);
        err_c = active && (state_nxt == S_IDLE);
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            waddr       <= '0;
            wdata       <= '0;
            write_en    <= 1'b0;
            ask_for_ram <= 1'b0;
            end_of_data <= 1'b0;
            load_ok     <= 1'b0;
            load_err    <= 1'b0;
            addr_h      <= '0;
            len_h       <= '0;
            ptr         <= '0;
            rem         <= '0;
            tmo         <= '0;
            rb_cnt      <= '0;
        end else begin
            write_en    <= wr_c;
            load_ok     <= ok_c;
            load_err    <= err_c;
            ask_for_ram <= (state_nxt inside {S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK});
            end_of_data <= (state_nxt == S_REBOOT);

            if (rx_data_strobe)          tmo <= TIMEOUT_CYC;
            else if (active && tmo != '0) tmo <= tmo - TIMEOUT_W'(1);

            if (rx_data_strobe) begin
                case (state)
                    S_ADDR_H: addr_h <= rx_data;
                    S_ADDR_L: ptr    <= ADDR_W'({addr_h, rx_data});
                    S_LEN_H:  len_h  <= rx_data;
                    S_LEN_L:  rem    <= {len_h, rx_data};
                    S_DATA: begin
                        waddr <= ptr;
                        wdata <= rx_data;
                        ptr   <= ptr + ADDR_W'(1);
                        rem   <= rem - 16'd1;
                    end
                    default: ;
                endcase
            end

            // Reboot window length: REBOOT_CYC cycles spent in S_REBOOT.
            if (ok_c)                                 rb_cnt <= RB_W'(REBOOT_CYC - 1);
            else if (state == S_REBOOT && rb_cnt != '0) rb_cnt <= rb_cnt - RB_W'(1);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_ram) begin
        if (reset)
            chk <= '0;
        else if (rx_data_strobe && state == S_IDLE)
            chk <= '0;
        else if (rx_data_strobe && state == S_DATA)
            chk <= chk ^ rx_data;
    end
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed vector table plus hand sequences for reboot, timeout and reset.
// Builds with or without PROG_LOADER_CHECKSUM_EN; expectations follow the same macro.
module tb_uart_prog_loader;

    logic        clk_ram = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_data_strobe;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        write_en, ask_for_ram, end_of_data, load_ok, load_err;

    uart_prog_loader #(
        .ADDR_W      (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_W   (20),
        .TIMEOUT_CYC (20'd100),
        .REBOOT_CYC  (80)
    ) dut (
        .clk_ram        (clk_ram),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_data_strobe (rx_data_strobe),
        .waddr          (waddr),
        .wdata          (wdata),
        .write_en       (write_en),
        .ask_for_ram    (ask_for_ram),
        .end_of_data    (end_of_data),
        .load_ok        (load_ok),
        .load_err       (load_err)
    );

    always #5 clk_ram = ~clk_ram;

    typedef struct {
        bit          stb;
        logic [7:0]  data;
        bit          we;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        bit          ask;
        bit          eod;
        bit          ok;
        bit          err;
    } vec_t;

    vec_t tbl[$];
    int   mark[7];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input bit stb, input logic [7:0] d, input bit we,
                                input logic [15:0] a, input logic [7:0] wd,
                                input bit ask, input bit eod, input bit ok, input bit err);
        vec_t v;
        v.stb = stb; v.data = d; v.we = we; v.waddr = a; v.wdata = wd;
        v.ask = ask; v.eod = eod; v.ok = ok; v.err = err;
        tbl.push_back(v);
    endfunction

    // Header byte: loader owns RAM, no write, write port holds its last values.
    function automatic void hdr(input logic [7:0] d, input logic [15:0] a, input logic [7:0] wd);
        add(1'b1, d, 1'b0, a, wd, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input bit pass, input string info);
        n_vec++;
        if (!pass) begin
            n_bad++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = tbl[i];
        rx_data        = v.data;
        rx_data_strobe = v.stb;
        @(negedge clk_ram);
        rx_data_strobe = 1'b0;
        check($sformatf("vec%0d", i),
              {write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err} ==
              {v.we, v.waddr, v.wdata, v.ask, v.eod, v.ok, v.err},
              $sformatf("got we=%0b a=%h d=%h ask=%0b eod=%0b ok=%0b err=%0b, want we=%0b a=%h d=%h ask=%0b eod=%0b ok=%0b err=%0b",
                        write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err,
                        v.we, v.waddr, v.wdata, v.ask, v.eod, v.ok, v.err));
    endtask

    task automatic run_seg(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply_vec(i);
    endtask

    // Entered on the first sample with end_of_data high; optionally fires a SYNC mid-window.
    task automatic reboot_window(input bit inject, input string name);
        int n;
        bit stray;
        n = 1;
        stray = 1'b0;
        while (end_of_data && n < 200) begin
            rx_data        = 8'hA5;
            rx_data_strobe = inject && (n == 10);
            @(negedge clk_ram);
            rx_data_strobe = 1'b0;
            if (ask_for_ram || load_ok || load_err || write_en) stray = 1'b1;
            if (end_of_data) n++;
        end
        check({name, "_len"}, n == 80, $sformatf("end_of_data cycles %0d, want 80", n));
        check({name, "_quiet"}, !stray, $sformatf("stray=%0b during reboot, want 0", stray));
        repeat (3) @(negedge clk_ram);
        check({name, "_idle"}, !ask_for_ram && !end_of_data,
              $sformatf("ask=%0b eod=%0b after reboot, want 0 0", ask_for_ram, end_of_data));
    endtask

    initial begin
        logic [15:0] la;
        logic [7:0]  ld;
        int          k;
        bit          got, early, stable;

        // Test 1: basic load at 0x0600.
        hdr(8'hA5, 16'h0000, 8'h00);
        hdr(8'h06, 16'h0000, 8'h00);
        hdr(8'h00, 16'h0000, 8'h00);
        hdr(8'h00, 16'h0000, 8'h00);
        hdr(8'h03, 16'h0000, 8'h00);
        add(1, 8'h11, 1, 16'h0600, 8'h11, 1, 0, 0, 0);
        add(1, 8'h22, 1, 16'h0601, 8'h22, 1, 0, 0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        add(1, 8'h33, 1, 16'h0602, 8'h33, 1, 0, 0, 0);
        add(1, 8'h00, 0, 16'h0602, 8'h33, 0, 1, 1, 0);
`else
        add(1, 8'h33, 1, 16'h0602, 8'h33, 0, 1, 1, 0);
`endif
        mark[0] = tbl.size();

        // Test 2: stray bytes while idle; Test 3: address wrap.
        add(1, 8'h00, 0, 16'h0602, 8'h33, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 16'h0602, 8'h33, 0, 0, 0, 0);
        add(1, 8'h5A, 0, 16'h0602, 8'h33, 0, 0, 0, 0);
        add(0, 8'h00, 0, 16'h0602, 8'h33, 0, 0, 0, 0);
        hdr(8'hA5, 16'h0602, 8'h33);
        hdr(8'hFF, 16'h0602, 8'h33);
        hdr(8'hFF, 16'h0602, 8'h33);
        hdr(8'h00, 16'h0602, 8'h33);
        hdr(8'h02, 16'h0602, 8'h33);
        add(1, 8'hAA, 1, 16'hFFFF, 8'hAA, 1, 0, 0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        add(1, 8'hBB, 1, 16'h0000, 8'hBB, 1, 0, 0, 0);
        add(1, 8'h11, 0, 16'h0000, 8'hBB, 0, 1, 1, 0);
`else
        add(1, 8'hBB, 1, 16'h0000, 8'hBB, 0, 1, 1, 0);
`endif
        mark[1] = tbl.size();

        // Test 4: bad checksum (required FF, sent 00).
`ifdef PROG_LOADER_CHECKSUM_EN
        hdr(8'hA5, 16'h0000, 8'hBB);
        hdr(8'h00, 16'h0000, 8'hBB);
        hdr(8'h10, 16'h0000, 8'hBB);
        hdr(8'h00, 16'h0000, 8'hBB);
        hdr(8'h02, 16'h0000, 8'hBB);
        add(1, 8'h0F, 1, 16'h0010, 8'h0F, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 16'h0011, 8'hF0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 16'h0011, 8'hF0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 16'h0011, 8'hF0, 0, 0, 0, 0);
        la = 16'h0011; ld = 8'hF0;
`else
        la = 16'h0000; ld = 8'hBB;
`endif
        mark[2] = tbl.size();

        // Test 5: truncated header, then timeout.
        hdr(8'hA5, la, ld);
        hdr(8'h00, la, ld);
        hdr(8'h10, la, ld);
        mark[3] = tbl.size();

        // Test 6: packet interrupted by reset after one payload byte.
        hdr(8'hA5, la, ld);
        hdr(8'h00, la, ld);
        hdr(8'h20, la, ld);
        hdr(8'h00, la, ld);
        hdr(8'h04, la, ld);
        add(1, 8'hAA, 1, 16'h0020, 8'hAA, 1, 0, 0, 0);
        mark[4] = tbl.size();

        // Fresh packet after reset, header only.
        hdr(8'hA5, 16'h0000, 8'h00);
        hdr(8'h01, 16'h0000, 8'h00);
        hdr(8'h00, 16'h0000, 8'h00);
        hdr(8'h00, 16'h0000, 8'h00);
        hdr(8'h01, 16'h0000, 8'h00);
        mark[5] = tbl.size();

        // Its single payload byte, after a long but legal gap.
`ifdef PROG_LOADER_CHECKSUM_EN
        add(1, 8'h7E, 1, 16'h0100, 8'h7E, 1, 0, 0, 0);
        add(1, 8'h7E, 0, 16'h0100, 8'h7E, 0, 1, 1, 0);
`else
        add(1, 8'h7E, 1, 16'h0100, 8'h7E, 0, 1, 1, 0);
`endif
        mark[6] = tbl.size();

        reset          = 1'b1;
        rx_data        = 8'h00;
        rx_data_strobe = 1'b0;
        repeat (3) @(negedge clk_ram);
        check("reset_state",
              {write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err} == 31'd0,
              $sformatf("got we=%0b a=%h d=%h ask=%0b eod=%0b ok=%0b err=%0b, want all 0",
                        write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err));
        reset = 1'b0;
        @(negedge clk_ram);

        run_seg(0, mark[0]);
        reboot_window(1'b1, "t1_reboot");

        run_seg(mark[0], mark[1]);
        reboot_window(1'b0, "t3_reboot");

        run_seg(mark[1], mark[2]);

        run_seg(mark[2], mark[3]);
        k = 0; got = 1'b0; early = 1'b0;
        while (!got && k < 300) begin
            @(negedge clk_ram);
            k++;
            got = load_err;
            if (!got && !ask_for_ram) early = 1'b1;
        end
        check("t5_timeout_fires", got && !early && k >= 95 && k <= 105,
              $sformatf("load_err after %0d cycles (seen=%0b early_release=%0b), want ~100",
                        k, got, early));
        check("t5_abort_outputs", !ask_for_ram && !end_of_data && !load_ok,
              $sformatf("ask=%0b eod=%0b ok=%0b at abort, want 0 0 0",
                        ask_for_ram, end_of_data, load_ok));
        @(negedge clk_ram);
        check("t5_err_pulse", !load_err && !ask_for_ram && !end_of_data,
              $sformatf("err=%0b ask=%0b eod=%0b after abort, want 0 0 0",
                        load_err, ask_for_ram, end_of_data));

        run_seg(mark[3], mark[4]);
        reset = 1'b1;
        @(negedge clk_ram);
        check("t6_reset_mid_payload",
              {write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err} == 31'd0,
              $sformatf("got we=%0b a=%h d=%h ask=%0b eod=%0b ok=%0b err=%0b, want all 0",
                        write_en, waddr, wdata, ask_for_ram, end_of_data, load_ok, load_err));
        reset = 1'b0;

        run_seg(mark[4], mark[5]);
        stable = 1'b1;
        repeat (80) begin
            @(negedge clk_ram);
            if (!ask_for_ram || load_err || write_en) stable = 1'b0;
        end
        check("t6_gap_holds", stable,
              $sformatf("ask=%0b err=%0b during 80-cycle gap, want 1 0", ask_for_ram, load_err));

        run_seg(mark[5], mark[6]);
        reboot_window(1'b1, "t6_reboot");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
